// File: rtl/zx_port_bank.sv
// zx_port_bank: NPORTS CPU-writable 8-bit I/O ports with glitch-qualified one-shot commit,
// per-port enables, a self-lock and write strobes. Define PORT_READBACK_EN to enable readback.
module zx_port_bank #(
  parameter int                   NPORTS     = 4,
  parameter logic [NPORTS*16-1:0] ADDR_LIST  = {4{16'h0000}},
  parameter logic [NPORTS*16-1:0] MASK_LIST  = {4{16'hFFFF}},
  parameter logic [NPORTS*8-1:0]  RESET_LIST = {4{8'h00}},
  parameter int                   LOCK_PORT  = -1,
  parameter int                   LOCK_BIT   = 5
) (
  input  logic                  i_clk28,
  input  logic                  i_rst,
  input  logic [NPORTS-1:0]     i_port_en,
  input  logic                  i_lock_override,
  input  logic [15:0]           i_bus_a,
  input  logic [7:0]            i_bus_d,
  input  logic                  i_bus_ioreq,
  input  logic                  i_bus_rd,
  input  logic                  i_bus_wr,
  output logic [NPORTS*8-1:0]   o_port_q,
  output logic [NPORTS-1:0]     o_wr_stb,
  output logic                  o_locked,
  output logic [7:0]            o_d_out,
  output logic                  o_d_out_active
);

  localparam int SELW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_QUAL = 2'd1,
    ST_ACT  = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [NPORTS*8-1:0] r_port_q;
  logic [NPORTS-1:0]   r_wr_stb;
  logic [SELW-1:0]     r_sel;
  logic                r_armed;
  logic [NPORTS-1:0]   w_hit;
  logic [SELW-1:0]     w_sel;
  logic                w_req;
  logic                w_latch_sel;
  logic                w_act_go;
  logic                w_hold_exit;
  logic                w_locked;
  logic                w_lock_block;

  // Address/mask decode per port, lowest matching index wins
  always_comb begin
    w_hit = {NPORTS{1'b0}};
    w_sel = {SELW{1'b0}};
    for (int i = 0; i < NPORTS; i++) begin
      w_hit[i] = i_port_en[i] &
                 (((i_bus_a ^ ADDR_LIST[16*i +: 16]) & MASK_LIST[16*i +: 16]) == 16'h0000);
    end
    for (int i = NPORTS - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_sel = SELW'(i);
      end else begin
        w_sel = w_sel;
      end
    end
  end

  assign w_req = i_bus_ioreq & (i_bus_rd | i_bus_wr) & (|w_hit);

  generate
    if (LOCK_PORT >= 0 && LOCK_PORT < NPORTS) begin : g_lock
      assign w_locked     = r_port_q[LOCK_PORT*8 + LOCK_BIT] & ~i_lock_override;
      assign w_lock_block = w_locked & (r_sel == SELW'(LOCK_PORT));
    end else begin : g_nolock
      logic w_unused_lock;
      assign w_unused_lock = i_lock_override;
      assign w_locked      = 1'b0;
      assign w_lock_block  = 1'b0;
    end
  endgenerate

  // FSM state register
  always_ff @(posedge i_clk28) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and the single-cycle control strobes for the datapath
  always_comb begin
    w_state_nxt = r_state;
    w_latch_sel = 1'b0;
    w_act_go    = 1'b0;
    w_hold_exit = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // after reset, an access already on the bus must end before a new one is accepted
        if (r_armed & w_req) begin
          w_state_nxt = ST_QUAL;
          w_latch_sel = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_QUAL: begin
        if (w_req & (w_sel == r_sel)) begin
          w_state_nxt = ST_ACT;
          w_act_go    = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACT: begin
        w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (!i_bus_ioreq) begin
          w_state_nxt = ST_IDLE;
          w_hold_exit = 1'b1;
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Arming, select latch, port commit and write strobes
  always_ff @(posedge i_clk28) begin
    if (i_rst) begin
      r_armed  <= 1'b0;
      r_sel    <= {SELW{1'b0}};
      r_port_q <= RESET_LIST;
      r_wr_stb <= {NPORTS{1'b0}};
    end else begin
      r_wr_stb <= {NPORTS{1'b0}};
      if (!i_bus_ioreq) begin
        r_armed <= 1'b1;
      end
      if (w_latch_sel) begin
        r_sel <= w_sel;
      end
      // commit lands on the QUAL->ACT edge so port_q and wr_stb are both valid during ACT
      if (w_act_go && i_bus_wr && !w_lock_block) begin
        for (int i = 0; i < NPORTS; i++) begin
          if (r_sel == SELW'(i)) begin
            r_port_q[8*i +: 8] <= i_bus_d;
            r_wr_stb[i]        <= 1'b1;
          end
        end
      end
    end
  end

`ifdef PORT_READBACK_EN
  logic [7:0] r_d_out;
  logic       r_d_out_active;
  logic [7:0] w_sel_q;

  // Value of the currently selected port
  always_comb begin
    w_sel_q = 8'hFF;
    for (int i = 0; i < NPORTS; i++) begin
      if (r_sel == SELW'(i)) begin
        w_sel_q = r_port_q[8*i +: 8];
      end else begin
        w_sel_q = w_sel_q;
      end
    end
  end

  // Readback captured entering ACT, held through HOLD, released when ioreq is seen low
  always_ff @(posedge i_clk28) begin
    if (i_rst) begin
      r_d_out        <= 8'hFF;
      r_d_out_active <= 1'b0;
    end else if (w_act_go && !i_bus_wr) begin
      r_d_out        <= w_sel_q;
      r_d_out_active <= 1'b1;
    end else if (w_hold_exit) begin
      r_d_out        <= 8'hFF;
      r_d_out_active <= 1'b0;
    end
  end

  assign o_d_out        = r_d_out;
  assign o_d_out_active = r_d_out_active;
`else
  assign o_d_out        = 8'hFF;
  assign o_d_out_active = 1'b0;
`endif

  assign o_port_q = r_port_q;
  assign o_wr_stb = r_wr_stb;
  assign o_locked = w_locked;

endmodule

// File: doc/zx_port_bank.md
Name: zx_port_bank

Overview:
- Parametrised bank of NPORTS CPU-writable 8-bit configuration ports, each with its own address/mask decode. Successor to the fixed per-port write decoders.
- Adds one-shot commit per I/O cycle with glitch qualification, per-port enables, a generalised write-lock, write strobes and optional readback.
- Sits between the Z80 bus and memory/video/peripheral control logic in the clk28 domain.

Parameters:
NPORTS, 4, number of ports (1..8)
ADDR_LIST, {4{16'h0000}}, NPORTS×16 packed match addresses; port i at bits [16i+15:16i]
MASK_LIST, {4{16'hFFFF}}, NPORTS×16 packed masks; 1 = address bit compared
RESET_LIST, {4{8'h00}}, NPORTS×8 packed reset values
LOCK_PORT, -1, index of the self-locking port; -1 = no lock
LOCK_BIT, 5, bit of port LOCK_PORT that sets the lock

Ports:
clk28  in  1  system clock, 28 MHz
rst  in  1  synchronous reset, active-high
port_en  in  NPORTS  per-port decode enable (machine/magic gating done outside)
lock_override  in  1  1 = ignore the lock
bus_a  in  16  CPU address
bus_d  in  8  CPU data out
bus_ioreq  in  1  I/O request, active-high
bus_rd  in  1  read, active-high
bus_wr  in  1  write, active-high
port_q  out  NPORTS×8  current port values; port i at [8i+7:8i]
wr_stb  out  NPORTS  one-clk28 pulse on a committed write to port i
locked  out  1  lock currently active
d_out  out  8  readback data
d_out_active  out  1  bank drives the data bus

Behaviour:
- Interface: one clock, clk28. Reset rst is synchronous and active-high.
- Match: hit[i] = port_en[i] & ((bus_a ^ ADDR_i) & MASK_i) == 0. With several hits, the lowest index wins. sel is the winning index, latched at qualification.
- FSM states: IDLE, QUAL, ACT, HOLD. It advances on clk28 edges.
  - IDLE -> QUAL when bus_ioreq & (bus_rd | bus_wr) & |hit.
  - QUAL -> ACT if the same condition holds on the next clk28 edge with the same sel. Otherwise QUAL -> IDLE (glitch rejected).
  - ACT lasts one cycle. On a write, port_q[sel] <= bus_d and wr_stb[sel] = 1 for exactly this cycle, unless blocked by the lock. Then ACT -> HOLD.
  - HOLD -> IDLE when bus_ioreq = 0. No further commit until then, so one write per I/O cycle regardless of bus_wr length.
- Write latency: bus_d appears on port_q 2 clk28 after the first sampled write cycle. wr_stb is asserted in the same cycle port_q updates.
- Lock (LOCK_PORT ≥ 0):
  - locked = port_q[LOCK_PORT][LOCK_BIT] & ~lock_override.
  - A write to LOCK_PORT while locked is dropped: port_q and wr_stb are unchanged, and the FSM still passes ACT -> HOLD.
  - Other ports are never locked.
  - The write that sets the lock bit itself is committed.
  - With LOCK_PORT = -1, locked = 0.
- Reads (see feature): d_out_active = 1 in ACT and HOLD when the access is a read. It drops in the cycle after bus_ioreq falls.
- bus_rd and bus_wr both high: treated as a write, no readback.
- rst at any time:
  - FSM -> IDLE.
  - port_q = RESET_LIST.
  - wr_stb = 0, d_out_active = 0, d_out = 8'hFF.
  - locked is derived from the reset value.
  - An in-flight access is abandoned and not re-committed, even if bus_ioreq is still high after reset. The FSM needs bus_ioreq = 0 first, so it waits in HOLD-equivalent: IDLE ignores ioreq until it is seen low once.

Optional Feature:
PORT_READBACK_EN
- Defined: on a read access, d_out = port_q[sel] registered in ACT and held through HOLD, and d_out_active is as above.
- Undefined: d_out = 8'hFF and d_out_active = 0 always. Reads still traverse the FSM but have no effect.

Test Plan:
- Reset with RESET_LIST port0 = 8'h10 -> port_q[7:0] = 8'h10, wr_stb = 0, d_out = 8'hFF, locked = 0.
- Port0 ADDR = 16'h7FFD, MASK = 16'h8002. bus_a = 16'h7FFD, bus_d = 8'h07, write held 10 clk28 -> port_q[7:0] = 8'h07 at cycle 2, one wr_stb[0] pulse only.
- LOCK_PORT = 0. Write 8'h20, then 8'h03 -> port_q[7:0] stays 8'h20, no second wr_stb, locked = 1. Repeat with lock_override = 1 -> 8'h03 committed.
- 1-cycle ioreq & wr glitch to port1 -> no change, FSM back to IDLE. Overlapping masks matching ports 1 and 2 -> only port1 written.
- PORT_READBACK_EN defined: read port1 holding 8'hA5 -> d_out = 8'hA5, d_out_active high from ACT until 1 cycle after ioreq falls. Undefined -> d_out_active stays 0.
- rst asserted in QUAL of a write, then released with ioreq still high -> port_q = reset values, no commit until a new I/O cycle.
